tlda_line_engine: RTL

- Bresenham line-drawing engine that sits directly upstream of the Avalon pixel-write master in the line-draw accelerator.
- Accepts two endpoints and a colour from the control/slave side.
- Walks every pixel of the line and presents one pixel at a time (Draw/Pixel_Address/Color) to the write master.
- Advances only when the master returns Write_Finish_to_LDA.

---
 rtl/tlda_pkg.sv | 24 ++
 rtl/tlda_pixel_addr.sv | 25 ++
 rtl/tlda_line_engine.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tlda_pkg.sv
// Shared definitions for the line-draw accelerator: FSM encodings, default
// pixel-buffer geometry and a coordinate-width helper.
package tlda_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } tlda_state_e;

   localparam int          TLDA_DEF_X_W   = 9;
   localparam int          TLDA_DEF_Y_W   = 8;
   localparam logic [31:0] TLDA_BASE_ADDR = 32'h0800_0000;
   localparam int          TLDA_ROW_SHIFT = 10;
   localparam int          TLDA_SCREEN_W  = 320;
   localparam int          TLDA_SCREEN_H  = 240;

   // Internal coordinate width: wide enough for either axis after a steep swap.
   function automatic int tlda_coord_w(input int xw, input int yw);
      return (xw > yw) ? xw : yw;
   endfunction

endpackage

// File: rtl/tlda_pixel_addr.sv
// Combinational screen coordinate to byte address translation, plus the
// visible-area compare. Shared by the line engine and other fill blocks.
module tlda_pixel_addr
   import tlda_pkg::*;
#(
   parameter int          X_W       = TLDA_DEF_X_W,
   parameter int          Y_W       = TLDA_DEF_Y_W,
   parameter logic [31:0] BASE_ADDR = TLDA_BASE_ADDR,
   parameter int          ROW_SHIFT = TLDA_ROW_SHIFT,
   parameter int          SCREEN_W  = TLDA_SCREEN_W,
   parameter int          SCREEN_H  = TLDA_SCREEN_H
)(
   input  logic [X_W-1:0] px_i,
   input  logic [Y_W-1:0] py_i,
   output logic [31:0]    addr_o,
   output logic           offscreen_o
);

   // Row pitch is 1 << ROW_SHIFT bytes, two bytes per RGB565 pixel.
   always_comb begin
      addr_o      = BASE_ADDR + (32'(py_i) << ROW_SHIFT) + (32'(px_i) << 1);
      offscreen_o = (32'(px_i) >= 32'(SCREEN_W)) || (32'(py_i) >= 32'(SCREEN_H));
   end

endmodule

// File: rtl/tlda_line_engine.sv
// Bresenham line engine feeding the Avalon pixel-write master. One pixel is
// presented at a time and advanced on Write_Finish_to_LDA.
// Optional macro TLDA_CLIP_EN: off-screen pixels are stepped over without Draw.
module tlda_line_engine
   import tlda_pkg::*;
#(
   parameter int          X_W       = TLDA_DEF_X_W,
   parameter int          Y_W       = TLDA_DEF_Y_W,
   parameter logic [31:0] BASE_ADDR = TLDA_BASE_ADDR,
   parameter int          ROW_SHIFT = TLDA_ROW_SHIFT,
   parameter int          SCREEN_W  = TLDA_SCREEN_W,
   parameter int          SCREEN_H  = TLDA_SCREEN_H
)(
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic [X_W-1:0] x0,
   input  logic [Y_W-1:0] y0,
   input  logic [X_W-1:0] x1,
   input  logic [Y_W-1:0] y1,
   input  logic [15:0]    color,
   output logic           busy,
   output logic           done,
   output logic           Draw_from_LDA,
   output logic [31:0]    Pixel_Address_from_LDA,
   output logic [15:0]    Color_from_LDA,
   input  logic           Write_Finish_to_LDA
);

   localparam int CW = tlda_coord_w(X_W, Y_W);
   localparam int EW = CW + 2;
`ifdef TLDA_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   tlda_state_e          state_q, state_d;
   logic [CW-1:0]        lx0_q, ly0_q, lx1_q, ly1_q, lx0_d, ly0_d, lx1_d, ly1_d;
   logic [15:0]          color_q, color_d;
   logic [CW-1:0]        x_q, y_q, xend_q, dx_q, dy_q, x_d, y_d, xend_d, dx_d, dy_d;
   logic signed [EW-1:0] err_q, err_d, err_t;
   logic                 steep_q, steep_d, ydec_q, ydec_d, last_q, last_d, draw_q, draw_d;
   logic [31:0]          addr_q, addr_d, addr_n;
   logic                 off_q, off_d, off_n, load_pix, skip, advance;
   logic [X_W-1:0]       px_n;
   logic [Y_W-1:0]       py_n;

   // Setup geometry: octant fold (steep swap, then endpoint order) of the latched line.
   logic [CW-1:0] adx, ady, ax0, ay0, ax1, ay1, sx0, sy0, sx1, sy1, sdx, sdy;
   logic          steep_s, swap_s, sdec;
   always_comb begin
      adx     = (lx1_q >= lx0_q) ? lx1_q - lx0_q : lx0_q - lx1_q;
      ady     = (ly1_q >= ly0_q) ? ly1_q - ly0_q : ly0_q - ly1_q;
      steep_s = ady > adx;
      ax0     = steep_s ? ly0_q : lx0_q;
      ay0     = steep_s ? lx0_q : ly0_q;
      ax1     = steep_s ? ly1_q : lx1_q;
      ay1     = steep_s ? lx1_q : ly1_q;
      swap_s  = ax0 > ax1;
      sx0     = swap_s ? ax1 : ax0;
      sy0     = swap_s ? ay1 : ay0;
      sx1     = swap_s ? ax0 : ax1;
      sy1     = swap_s ? ay0 : ay1;
      sdx     = sx1 - sx0;
      sdy     = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
      sdec    = sy1 < sy0;
   end

   // Off-screen pixels are only skipped when clipping is built in.
   assign skip    = CLIP_EN && off_q;
   assign advance = skip || Write_Finish_to_LDA;

   // FSM next state and Bresenham step.
   always_comb begin
      state_d  = state_q;
      lx0_d    = lx0_q;
      ly0_d    = ly0_q;
      lx1_d    = lx1_q;
      ly1_d    = ly1_q;
      color_d  = color_q;
      x_d      = x_q;
      y_d      = y_q;
      xend_d   = xend_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      err_t    = err_q;
      steep_d  = steep_q;
      ydec_d   = ydec_q;
      last_d   = last_q;
      draw_d   = draw_q;
      load_pix = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               lx0_d   = CW'(x0);
               ly0_d   = CW'(y0);
               lx1_d   = CW'(x1);
               ly1_d   = CW'(y1);
               color_d = color;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            x_d      = sx0;
            y_d      = sy0;
            xend_d   = sx1;
            dx_d     = sdx;
            dy_d     = sdy;
            err_d    = $signed({2'b00, sdx >> 1});
            steep_d  = steep_s;
            ydec_d   = sdec;
            last_d   = (sx0 == sx1);
            draw_d   = 1'b1;
            load_pix = 1'b1;
            state_d  = ST_DRAW;
         end
         ST_DRAW: begin
            if (advance) begin
               if (last_q) begin
                  draw_d  = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  x_d   = x_q + CW'(1);
                  err_t = err_q - $signed({2'b00, dy_q});
                  if (err_t < 0) begin
                     y_d   = ydec_q ? y_q - CW'(1) : y_q + CW'(1);
                     err_t = err_t + $signed({2'b00, dx_q});
                  end
                  err_d    = err_t;
                  last_d   = ((x_q + CW'(1)) == xend_q);
                  load_pix = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Address of the pixel being loaded; (px,py) un-swaps steep lines.
   assign px_n = steep_d ? y_d[X_W-1:0] : x_d[X_W-1:0];
   assign py_n = steep_d ? x_d[Y_W-1:0] : y_d[Y_W-1:0];

   tlda_pixel_addr #(
      .X_W       (X_W),
      .Y_W       (Y_W),
      .BASE_ADDR (BASE_ADDR),
      .ROW_SHIFT (ROW_SHIFT),
      .SCREEN_W  (SCREEN_W),
      .SCREEN_H  (SCREEN_H)
   ) u_pixel_addr (
      .px_i        (px_n),
      .py_i        (py_n),
      .addr_o      (addr_n),
      .offscreen_o (off_n)
   );

   assign addr_d = load_pix ? addr_n : addr_q;
   assign off_d  = load_pix ? off_n  : off_q;

   // State and datapath registers; reset abandons any line in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         lx0_q   <= '0;
         ly0_q   <= '0;
         lx1_q   <= '0;
         ly1_q   <= '0;
         color_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         xend_q  <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         steep_q <= 1'b0;
         ydec_q  <= 1'b0;
         last_q  <= 1'b0;
         draw_q  <= 1'b0;
         addr_q  <= '0;
         off_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lx0_q   <= lx0_d;
         ly0_q   <= ly0_d;
         lx1_q   <= lx1_d;
         ly1_q   <= ly1_d;
         color_q <= color_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xend_q  <= xend_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         steep_q <= steep_d;
         ydec_q  <= ydec_d;
         last_q  <= last_d;
         draw_q  <= draw_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
      end
   end

   // Draw drops in the same cycle the last pixel finishes so it is never rewritten.
   assign Draw_from_LDA          = draw_q && !skip && !(Write_Finish_to_LDA && last_q);
   assign Pixel_Address_from_LDA = addr_q;
   assign Color_from_LDA         = color_q;
   assign busy                   = (state_q != ST_IDLE);
   assign done                   = (state_q == ST_DONE);

endmodule
